// File: rtl/debounce_pkg.sv
// Shared types and constants for the scanned debounce controller.
package debounce_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } scan_state_e;

  localparam int unsigned DEF_CNT_W = 5;
  localparam int unsigned DEF_THR   = 30;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// N-bit two-flop synchronizer for raw asynchronous inputs.
module debounce_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Two back-to-back flops resolve metastability before internal use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign d_o = s2_q;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed debounce controller: one shared compare/increment unit
// visits channels round-robin, flips a channel after thr+1 consecutive
// mismatching visits and reports each flip through a one-entry event port.
// Optional: define DEBOUNCE_SCAN_STATUS_EN to add the busy status output.
module debounce_scan_ctrl
  import debounce_pkg::*;
#(
  parameter int unsigned  N_CH        = 8,
  parameter int unsigned  CNT_W       = DEF_CNT_W,
  parameter int unsigned  DEFAULT_THR = DEF_THR,
  parameter int unsigned  SCAN_DIV    = 1,
  localparam int unsigned PTR_W       = ptr_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  d_in,
  input  logic [CNT_W-1:0] thr_in,
  input  logic             thr_load,
  output logic [N_CH-1:0]  q,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [PTR_W-1:0] evt_ch,
  output logic             evt_level,
  output logic             evt_overrun,
  input  logic             ovr_clr
`ifdef DEBOUNCE_SCAN_STATUS_EN
  ,
  output logic [N_CH-1:0]  busy
`endif
);

  logic [N_CH-1:0]             sync_d;
  logic                        tick;
  scan_state_e                 state_q;
  logic [PTR_W-1:0]            ptr_q;
  logic [N_CH-1:0]             q_q;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]            thr_q;
  logic [CNT_W-1:0]            thr_pend_q;
  logic                        evt_valid_q;
  logic [PTR_W-1:0]            evt_ch_q;
  logic                        evt_level_q;
  logic                        ovr_q;

  logic                        cur_sync;
  logic                        cur_q;
  logic [CNT_W-1:0]            cur_cnt;
  logic [CNT_W-1:0]            cnt_d;
  logic                        flip;

  debounce_sync #(.W(N_CH)) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (d_in),
    .d_o    (sync_d)
  );

  generate
    if (SCAN_DIV <= 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int unsigned DIV_W = $clog2(SCAN_DIV);
      logic [DIV_W-1:0] div_q;

      // Prescaler: one scan tick every SCAN_DIV clocks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          div_q <= '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
          div_q <= '0;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end

      assign tick = (div_q == DIV_W'(SCAN_DIV - 1));
    end
  endgenerate

  // Shared compare/increment unit for the channel under the scan pointer.
  always_comb begin
    cur_sync = sync_d[ptr_q];
    cur_q    = q_q[ptr_q];
    cur_cnt  = cnt_q[ptr_q];
    cnt_d    = '0;
    flip     = 1'b0;
    if (state_q == ST_RUN && (cur_sync != cur_q)) begin
      // cnt only increments while below thr, so it can never wrap.
      if (cur_cnt >= thr_q) begin
        flip = tick;
      end else begin
        cnt_d = cur_cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_SCAN_STATUS_EN
  logic [N_CH-1:0] busy_q;
  assign busy = busy_q;
`endif

  // Scan FSM: initial level capture pass, then per-visit count/flip updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      thr_q      <= CNT_W'(DEFAULT_THR);
      thr_pend_q <= CNT_W'(DEFAULT_THR);
`ifdef DEBOUNCE_SCAN_STATUS_EN
      busy_q     <= '0;
`endif
    end else begin
      if (thr_load) begin
        thr_pend_q <= thr_in;
      end
      if (tick) begin
        if (state_q == ST_INIT) begin
          q_q[ptr_q]   <= cur_sync;
          cnt_q[ptr_q] <= '0;
        end else begin
          cnt_q[ptr_q] <= cnt_d;
          if (flip) begin
            q_q[ptr_q] <= ~cur_q;
          end
        end
`ifdef DEBOUNCE_SCAN_STATUS_EN
        busy_q[ptr_q] <= (cnt_d != '0);
`endif
        // Threshold only changes at the pass boundary so a pass is uniform.
        if (ptr_q == PTR_W'(N_CH - 1)) begin
          ptr_q   <= '0;
          thr_q   <= thr_pend_q;
          state_q <= ST_RUN;
        end else begin
          ptr_q   <= ptr_q + 1'b1;
        end
      end
    end
  end

  // Single-entry event holding register with sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_level_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (ovr_clr) begin
        ovr_q <= 1'b0;
      end
      if (flip) begin
        if (!evt_valid_q || evt_ready) begin
          evt_valid_q <= 1'b1;
          evt_ch_q    <= ptr_q;
          evt_level_q <= ~cur_q;
        end else begin
          // Overrun beats a simultaneous clear.
          ovr_q <= 1'b1;
        end
      end else if (evt_ready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign q           = q_q;
  assign evt_valid   = evt_valid_q;
  assign evt_ch      = evt_ch_q;
  assign evt_level   = evt_level_q;
  assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl (N_CH=4, SCAN_DIV=1, thr=3).
module tb_debounce_scan_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] d_in = '0;
  logic [4:0] thr_in = '0;
  logic       thr_load = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [3:0] q;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic       evt_level;
  logic       evt_overrun;
`ifdef DEBOUNCE_SCAN_STATUS_EN
  logic [3:0] busy;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (timeline of visits, streak lengths, event slot)
  logic [3:0] m_q, m_s1, m_s2;
  int         m_run [N];
  int         m_thr, m_pend, m_vis, m_ev_ch;
  logic       m_ev, m_ev_lvl, m_ovr;

  // Observed transfers
  int         n_evt;
  logic [1:0] last_ch;
  logic       last_lvl;

  debounce_scan_ctrl #(
    .N_CH        (4),
    .CNT_W       (5),
    .DEFAULT_THR (3),
    .SCAN_DIV    (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_in        (d_in),
    .thr_in      (thr_in),
    .thr_load    (thr_load),
    .q           (q),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ch      (evt_ch),
    .evt_level   (evt_level),
    .evt_overrun (evt_overrun),
    .ovr_clr     (ovr_clr)
`ifdef DEBOUNCE_SCAN_STATUS_EN
    ,
    .busy        (busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = '0; m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_thr = 3; m_pend = 3; m_vis = 0;
    m_ev = 1'b0; m_ev_ch = 0; m_ev_lvl = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock of the reference: visit k goes to channel k mod N; a channel
  // flips once its streak of disagreeing samples exceeds the threshold.
  task automatic model_update();
    int  ch;
    bit  flip, lost;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ch = m_vis % N; flip = 0; lost = 0;
    if (m_vis < N) begin
      m_q[ch] = m_s2[ch];
      m_run[ch] = 0;
    end else if (m_s2[ch] != m_q[ch]) begin
      m_run[ch] = m_run[ch] + 1;
      if (m_run[ch] > m_thr) begin
        m_q[ch] = ~m_q[ch];
        m_run[ch] = 0;
        flip = 1;
      end
    end else begin
      m_run[ch] = 0;
    end
    if (flip) begin
      if (!m_ev || evt_ready) begin
        m_ev = 1'b1; m_ev_ch = ch; m_ev_lvl = m_q[ch];
      end else begin
        lost = 1;
      end
    end else if (m_ev && evt_ready) begin
      m_ev = 1'b0;
    end
    if (lost) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    if (ch == N - 1) m_thr = m_pend;
    if (thr_load) m_pend = int'(thr_in);
    m_vis = m_vis + 1;
    m_s2 = m_s1;
    m_s1 = d_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("q", 32'(q), 32'(m_q));
    chk("evt_valid", 32'(evt_valid), 32'(m_ev));
    chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
    if (m_ev) begin
      chk("evt_ch", 32'(evt_ch), 32'(m_ev_ch));
      chk("evt_level", 32'(evt_level), 32'(m_ev_lvl));
    end
    if (evt_valid === 1'b1 && evt_ready) begin
      n_evt++;
      last_ch = evt_ch;
      last_lvl = evt_level;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    model_reset();
    n_evt = 0; last_ch = '0; last_lvl = 1'b0;

    // Reset state, then settle with a held input pattern
    d_in = 4'b1010;
    evt_ready = 1'b1;
    step(2);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_evt_valid", 32'(evt_valid), 32'h0);
    rst_n = 1'b1;
    step(30);
    chk("init_q", 32'(q), 32'hA);
    chk("init_ovr", 32'(evt_overrun), 32'h0);

    // Single held change on channel 2
    n_evt = 0;
    d_in[2] = 1'b1;
    step(20);
    chk("ch2_rise_q", 32'(q[2]), 32'h1);
    chk("ch2_evt_count", 32'(n_evt), 32'h1);
    chk("ch2_evt_ch", 32'(last_ch), 32'h2);
    chk("ch2_evt_level", 32'(last_lvl), 32'h1);

    // Short runs on channel 1 are filtered out
    n_evt = 0;
    for (int i = 0; i < 8; i++) begin
      d_in[1] = ~d_in[1];
      step(6);
    end
    chk("glitch_q1", 32'(q[1]), 32'h1);
    chk("glitch_evt_count", 32'(n_evt), 32'h0);

    // Consumer stalled: first event held, second dropped
    evt_ready = 1'b0;
    d_in[0] = 1'b1;
    step(20);
    d_in[3] = 1'b0;
    step(20);
    chk("held_valid", 32'(evt_valid), 32'h1);
    chk("held_ch", 32'(evt_ch), 32'h0);
    chk("held_level", 32'(evt_level), 32'h1);
    chk("overrun_set", 32'(evt_overrun), 32'h1);
    chk("dropped_q3", 32'(q[3]), 32'h0);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("overrun_clr", 32'(evt_overrun), 32'h0);
    evt_ready = 1'b1;
    step(2);
    chk("drained", 32'(evt_valid), 32'h0);

    // Threshold 0 loaded mid-pass; old value holds until the wrap
    thr_in = 5'd0;
    step(2);
    d_in[0] = 1'b0;
    thr_load = 1'b1;
    step(1);
    thr_load = 1'b0;
    step(8);
    d_in[2] = 1'b0;
    step(7);
    chk("thr0_fast_flip", 32'(q[2]), 32'h0);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) d_in[$urandom_range(0, 3)] ^= 1'b1;
      evt_ready = 1'($urandom_range(0, 1));
      thr_load  = ($urandom_range(0, 19) == 0);
      thr_in    = 5'($urandom_range(0, 3));
      ovr_clr   = ($urandom_range(0, 9) == 0);
      step(1);
    end
    thr_load = 1'b0;
    ovr_clr = 1'b0;

    // Asynchronous reset with an event pending and counters in flight
    evt_ready = 1'b0;
    d_in[0] = ~d_in[0];
    step(30);
    chk("pre_reset_valid", 32'(evt_valid), 32'h1);
    d_in[1] = ~d_in[1];
    step(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    chk("async_rst_valid", 32'(evt_valid), 32'h0);
    chk("async_rst_ovr", 32'(evt_overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(30);
    chk("reinit_q", 32'(q), 32'(d_in));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
